// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester round-robin front end for the shared 8-bit ALU.
// Accepts one operation at a time, drives the ALU from registers, waits out the
// ALU pipeline latency, then holds the captured result until the granted
// requester takes it.
module alu_req_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_a0,
    input  logic [7:0]  req_b0,
    input  logic [1:0]  req_op0,
    input  logic [7:0]  req_a1,
    input  logic [7:0]  req_b1,
    input  logic [1:0]  req_op1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [7:0]  alu_out,
    output logic        busy,
    output logic [15:0] done_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Countdown start value; a 3-bit counter covers the legal 0..7 range.
    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t      state;
    logic        prio;      // requester that wins the next tie
    logic        gnt_id;    // requester owning the in-flight operation
    logic [2:0]  cnt;       // remaining ALU pipeline edges
    logic        any_valid;
    logic        gnt;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [1:0]  sel_op;

    assign busy = (state != S_IDLE);

    // Grant selection: sole requester wins, ties go to prio; ready only in IDLE out of reset.
    always_comb begin
        any_valid = |req_valid;
        gnt       = (req_valid == 2'b11) ? prio : req_valid[1];
        req_ready = 2'b00;
        if ((state == S_IDLE) && any_valid && !rst) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Payload of the currently selected requester.
    always_comb begin
        sel_a  = gnt ? req_a1  : req_a0;
        sel_b  = gnt ? req_b1  : req_b0;
        sel_op = gnt ? req_op1 : req_op0;
    end

    // Sequencer: accept -> latency countdown -> hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            gnt_id     <= 1'b0;
            cnt        <= 3'd0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_op     <= 2'd0;
            rsp_valid  <= 2'b00;
            rsp_data   <= 8'd0;
            done_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        gnt_id <= gnt;
                        prio   <= ~gnt;
                        cnt    <= LAT;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_valid <= gnt_id ? 2'b10 : 2'b01;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Only the granted requester's ready completes the handshake.
                    if (rsp_ready[gnt_id]) begin
                        done_count <= done_count + 16'd1;
                        rsp_valid  <= 2'b00;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: three arbiters (ALU latency 1, 3, 0) share one stimulus
// stream; each is compared every cycle against a transaction-level model, and
// directed steps pin specific results and latencies by hand.
module tb_alu_req_arbiter;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] rsp_ready = 2'b00;
    logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic [1:0] op0 = 2'd0, op1 = 2'd0;

    logic [1:0]  rr  [NI];
    logic [1:0]  rv  [NI];
    logic [7:0]  rd  [NI];
    logic [7:0]  aa  [NI];
    logic [7:0]  ab  [NI];
    logic [1:0]  aop [NI];
    logic        bz  [NI];
    logic [15:0] dc  [NI];

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            localparam int L = (k == 0) ? 1 : ((k == 1) ? 3 : 0);
            logic [7:0] f;
            logic [7:0] alu_o;
            assign f = alu_f(aa[k], ab[k], aop[k]);
            if (L == 0) begin : g_comb
                assign alu_o = f;
            end else begin : g_pipe
                logic [7:0] pipe [L];
                always @(posedge clk) begin
                    pipe[0] <= f;
                    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
                end
                assign alu_o = pipe[L-1];
            end
            alu_req_arbiter #(.ALU_LATENCY(L)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req_valid (req_valid),
                .req_ready (rr[k]),
                .req_a0    (a0),
                .req_b0    (b0),
                .req_op0   (op0),
                .req_a1    (a1),
                .req_b1    (b1),
                .req_op1   (op1),
                .rsp_valid (rv[k]),
                .rsp_ready (rsp_ready),
                .rsp_data  (rd[k]),
                .alu_a     (aa[k]),
                .alu_b     (ab[k]),
                .alu_op    (aop[k]),
                .alu_out   (alu_o),
                .busy      (bz[k]),
                .done_count(dc[k])
            );
        end
    endgenerate

    // Transaction model: an op accepted at cycle c is answered from cycle c+L+2
    // until its requester takes it.
    bit          m_inflight [NI];
    bit          m_gid      [NI];
    bit          m_prio     [NI];
    logic [7:0]  m_res      [NI];
    logic [7:0]  m_last     [NI];
    logic [7:0]  m_a        [NI];
    logic [7:0]  m_b        [NI];
    logic [1:0]  m_op       [NI];
    logic [15:0] m_done     [NI];
    int          m_rcyc     [NI];
    int          m_acc      [NI];
    int          lat_seen   [NI];
    bit          lat_got    [NI];
    int          gnt_log  [$];
    logic [7:0]  data_log [$];
    int          rv_seen = 0;

    task automatic model_reset(input int k);
        m_inflight[k] = 1'b0;
        m_gid[k]      = 1'b0;
        m_prio[k]     = 1'b0;
        m_res[k]      = 8'd0;
        m_last[k]     = 8'd0;
        m_a[k]        = 8'd0;
        m_b[k]        = 8'd0;
        m_op[k]       = 2'd0;
        m_done[k]     = 16'd0;
        m_rcyc[k]     = 0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            model_reset(k);
            lat_seen[k] = -1;
            lat_got[k]  = 1'b1;
            m_acc[k]    = 0;
        end
    end

    // Per-cycle compare against the model, then advance the model across the next edge.
    always @(negedge clk) begin
        ncyc++;
        if (armed) begin
            for (int k = 0; k < NI; k++) begin
                bit         vis;
                bit         g;
                logic [1:0] e_rr;
                logic [1:0] e_rv;
                logic [7:0] e_rd;
                vis  = m_inflight[k] && (ncyc >= m_rcyc[k]);
                e_rv = vis ? (m_gid[k] ? 2'b10 : 2'b01) : 2'b00;
                e_rd = vis ? m_res[k] : m_last[k];
                g    = (req_valid == 2'b11) ? m_prio[k] : req_valid[1];
                e_rr = 2'b00;
                if (!m_inflight[k] && !rst && (req_valid != 2'b00)) e_rr[g] = 1'b1;
                chk($sformatf("req_ready[%0d]", k), rr[k], e_rr);
                chk($sformatf("rsp_valid[%0d]", k), rv[k], e_rv);
                chk($sformatf("rsp_data[%0d]", k), rd[k], e_rd);
                chk($sformatf("alu_a[%0d]", k), aa[k], m_a[k]);
                chk($sformatf("alu_b[%0d]", k), ab[k], m_b[k]);
                chk($sformatf("alu_op[%0d]", k), aop[k], m_op[k]);
                chk($sformatf("busy[%0d]", k), bz[k], m_inflight[k]);
                chk($sformatf("done_count[%0d]", k), dc[k], m_done[k]);

                if (rv[k] != 2'b00) begin
                    rv_seen++;
                    if (!lat_got[k]) begin
                        lat_seen[k] = ncyc - m_acc[k] - 1;
                        lat_got[k]  = 1'b1;
                    end
                end
                if (k == 0 && rr[0] != 2'b00) gnt_log.push_back(int'(rr[0][1]));
                if (k == 0 && (rv[0] & rsp_ready) != 2'b00) data_log.push_back(rd[0]);

                if (rst) begin
                    model_reset(k);
                end else if (vis && rsp_ready[m_gid[k]]) begin
                    m_inflight[k] = 1'b0;
                    m_done[k]     = m_done[k] + 16'd1;
                    m_last[k]     = m_res[k];
                end else if (!m_inflight[k] && (req_valid != 2'b00)) begin
                    m_inflight[k] = 1'b1;
                    m_gid[k]      = g;
                    m_a[k]        = g ? a1 : a0;
                    m_b[k]        = g ? b1 : b0;
                    m_op[k]       = g ? op1 : op0;
                    m_res[k]      = alu_f(m_a[k], m_b[k], m_op[k]);
                    m_prio[k]     = ~g;
                    m_rcyc[k]     = ncyc + lat_of(k) + 2;
                    m_acc[k]      = ncyc;
                    lat_got[k]    = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((bz[0] || bz[1] || bz[2]) && t < 50) begin
            cyc(1);
            t++;
        end
        if (t >= 50) bound_fail(name);
    endtask

    // One-cycle request pulse on requester r; all instances are idle so all accept together.
    task automatic one_op(input bit r, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        if (r) begin a1 = a; b1 = b; op1 = op; end
        else   begin a0 = a; b0 = b; op0 = op; end
        req_valid = r ? 2'b10 : 2'b01;
        cyc(1);
        req_valid = 2'b00;
        wait_idle("op_idle");
    endtask

    task automatic last_data(input string name, input logic [7:0] exp);
        if (data_log.size() == 0) bound_fail(name);
        else chk(name, data_log[$], exp);
    endtask

    initial begin
        int t;
        int snap;
        @(posedge clk);
        #1;
        armed = 1'b1;
        cyc(2);
        rst = 1'b0;
        rsp_ready = 2'b11;

        // Single ADD
        a0 = 8'd42; b0 = 8'd99; op0 = 2'd0;
        req_valid = 2'b01;
        #1;
        chk("add_req_ready", rr[0], 2'b01);
        cyc(1);
        req_valid = 2'b00;
        wait_idle("add_idle");
        last_data("add_result", 8'd141);
        chk("add_done", dc[0], 16'd1);
        chk("lat1_edges", lat_seen[0], 32'd2);
        chk("lat3_edges", lat_seen[1], 32'd4);
        chk("lat0_edges", lat_seen[2], 32'd1);

        // Wrap-around
        one_op(1'b0, 8'd42, 8'd99, 2'd1);
        last_data("sub_wrap", 8'd199);
        one_op(1'b1, 8'd200, 8'd100, 2'd0);
        last_data("add_wrap", 8'd44);
        one_op(1'b0, 8'd1, 8'd0, 2'd2);
        last_data("and_zero", 8'd0);

        // Contention from reset, both held: grants alternate
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        gnt_log.delete();
        data_log.delete();
        a0 = 8'd99; b0 = 8'd42; op0 = 2'd1;
        a1 = 8'd1;  b1 = 8'd0;  op1 = 2'd3;
        req_valid = 2'b11;
        t = 0;
        while (dc[0] < 16'd4 && t < 60) begin cyc(1); t++; end
        if (t >= 60) bound_fail("contend_wait");
        req_valid = 2'b00;
        wait_idle("contend_idle");
        if (gnt_log.size() < 4 || data_log.size() < 4) bound_fail("contend_log");
        else begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("contend_gnt%0d", i), gnt_log[i], (i % 2));
                chk($sformatf("contend_data%0d", i), data_log[i], (i % 2) ? 8'd1 : 8'd57);
            end
        end

        // Backpressure in RESP; non-granted ready bit has no effect
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        rsp_ready = 2'b00;
        a0 = 8'd7; b0 = 8'd5; op0 = 2'd0;
        req_valid = 2'b01;
        cyc(1);
        req_valid = 2'b00;
        t = 0;
        while (rv[0] == 2'b00 && t < 10) begin cyc(1); t++; end
        if (t >= 10) bound_fail("bp_rsp_wait");
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("bp_rsp_valid", rv[0], 2'b01);
            chk("bp_rsp_data", rd[0], 8'd12);
            chk("bp_alu_a", aa[0], 8'd7);
            chk("bp_req_ready", rr[0], 2'b00);
            chk("bp_busy", bz[0], 1'b1);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        wait_idle("bp_idle");
        chk("bp_done", dc[0], 16'd1);

        // Reset during WAIT: nothing comes back, prio returns to requester 0
        a0 = 8'd9; b0 = 8'd3; op0 = 2'd0;
        req_valid = 2'b01;
        cyc(1);
        req_valid = 2'b00;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_busy", bz[0], 1'b0);
        chk("rst_rsp_valid", rv[0], 2'b00);
        chk("rst_alu_a", aa[0], 8'd0);
        chk("rst_done", dc[0], 16'd0);
        snap = rv_seen;
        cyc(10);
        chk("rst_no_rsp", rv_seen - snap, 32'd0);
        a1 = 8'd3; b1 = 8'd4; op1 = 2'd0;
        req_valid = 2'b11;
        #1;
        chk("rst_prio", rr[0], 2'b01);
        cyc(1);
        req_valid = 2'b00;
        wait_idle("rst_idle");
        last_data("rst_after_data", 8'd12);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester arbiter and sequencer for the shared 8-bit `simple_alu`. It accepts operation requests (a, b, op) over valid/ready handshakes and grants round-robin. It drives the ALU operand/op inputs from registers, waits the ALU's fixed pipeline latency, then returns the captured result to the granted requester over a second valid/ready handshake. One operation is in flight at a time; the block sits between requesting masters and the single ALU instance.

## Interface
- `ALU_LATENCY`, default 1: clock edges from ALU operands changing to `alu_out` valid. Legal range 0..7; 0 means a combinational ALU.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 2: bit i = requester i has a request.
- `req_ready` out 2: bit i = request i accepted this cycle (combinational).
- `req_a0`, `req_b0` in 8 each: operands of requester 0.
- `req_op0` in 2: op of requester 0 (0 ADD, 1 SUB, 2 AND, 3 OR).
- `req_a1`, `req_b1` in 8 each: operands of requester 1.
- `req_op1` in 2: op of requester 1.
- `rsp_valid` out 2: one-hot, result available for requester i.
- `rsp_ready` in 2: requester i accepts the result.
- `rsp_data` out 8: result.
- `alu_a`, `alu_b` out 8 each: ALU operands (registered).
- `alu_op` out 2: ALU op (registered).
- `alu_out` in 8: ALU result.
- `busy` out 1: high whenever state != IDLE.
- `done_count` out 16: completed response handshakes, wraps at 65535 -> 0.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - WAIT: latency countdown.
  - RESP: holds the response.
- Grant selection in IDLE:
  - Grant g = the sole valid requester.
  - If both are valid, g = `prio`.
  - `prio` resets to 0.
- `req_ready[g]` = (state==IDLE) & `req_valid[g]` & ~`rst`. The other bit is 0. Both bits are 0 outside IDLE.
- Accept edge (IDLE with `req_valid[g]`):
  - Load `alu_a`/`alu_b`/`alu_op` from requester g.
  - Latch `gnt_id` = g.
  - Set `prio` = ~g.
  - Load `cnt` = `ALU_LATENCY`.
  - Go to WAIT.
- WAIT:
  - If `cnt` != 0: decrement.
  - If `cnt` == 0: capture `alu_out` into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid[gnt_id]` = 1.
  - `rsp_data` and the `alu_*` outputs are held stable.
  - On `rsp_ready[gnt_id]`: increment `done_count`, clear `rsp_valid`, go to IDLE.
  - `rsp_ready` on the non-granted bit is ignored.
- No new request is accepted in the cycle of the response handshake.
- Arithmetic is modulo 256; the block passes ALU results through unmodified.
- Requesters hold their payload stable while `req_valid` is high. A requester may drop `req_valid` before being granted; arbitration is re-evaluated every IDLE cycle.
- Reset (any state, including mid-WAIT or RESP):
  - Next state is IDLE and `prio` = 0.
  - The in-flight result is discarded and no `rsp_valid` is issued for it.
  - Outputs go to: `alu_a`=`alu_b`=0, `alu_op`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `done_count`=0.
  - `req_ready` = 0 while `rst` is high.

## Timing
- Accept edge E0 -> `rsp_valid` high after edge E0+`ALU_LATENCY`+1 (2 cycles for the default).
- `alu_*` outputs change only on the accept edge.
- Throughput: one operation per `ALU_LATENCY`+3 cycles with `rsp_ready` held high (accept, wait cycles, response, back to IDLE).
- `req_ready` is a combinational function of state and `req_valid`. No other combinational input-to-output paths.
- `busy` rises the cycle after the accept edge and falls the cycle after the response handshake.

## Test plan
- **Single ADD:** reset, then `req_valid`=01 with a=42, b=99, op=0, `rsp_ready`=11 -> `req_ready`=01 in the first IDLE cycle; 2 cycles later `rsp_valid`=01 with `rsp_data`=141; `done_count`=1.
- **Contention:** both valid from reset with req0 SUB 99,42 and req1 OR 1,0 -> req0 served first (57), then req1 (1). Keep both asserted -> grants alternate 0,1,0,1.
- **Backpressure:** `rsp_ready`=00 for 5 cycles in RESP -> `rsp_valid`, `rsp_data`, `alu_*` held constant; `req_ready`=00; `busy`=1. Raising `rsp_ready[1]` while `gnt_id`=0 -> no effect.
- **Wrap-around:** SUB 42,99 -> 199; ADD 200,100 -> 44; AND 1,0 -> 0.
- **Reset mid-operation:** `rst` for 1 cycle during WAIT -> next cycle `busy`=0, `rsp_valid`=00, `alu_a`=0, `done_count`=0. No response appears in the following 10 cycles unless a new request arrives. The next contended grant goes to requester 0.
- **Latency parameter:** `ALU_LATENCY`=3 with an ALU model delayed 3 edges -> `rsp_valid` 4 cycles after the accept edge with the correct value. `ALU_LATENCY`=0 -> 1 cycle.
